difftest_arch_event_queue: RTL and testbench
============================================

// Module: difftest_arch_event_queue
// PURPOSE
//   Collects architectural trap events (interrupts/exceptions) from the commit stage and queues them,
//   one per cycle, to the DifftestArchEvent DPI sink, which has no backpressure of its own.
//   Normalises each event (interrupt beats exception), absorbs bursts when the difftest step is
//   throttled, and flags and counts losses so a missed trap never passes silently.
// PARAMETERS
//   DEPTH      4   queue entries; power of 2, >= 2
//   CNT_W      16  width of drop counter (saturating)
// PORTS
//   clock            in   1     single clock; all state on posedge
//   reset            in   1     synchronous, active-high
//   in_valid         in   1     commit stage reports a trap this cycle
//   in_interrupt     in   32    interrupt cause, 0 = none
//   in_exception     in   32    exception cause, 0 = none
//   in_exceptionPC   in   64    PC of trapping instruction
//   in_exceptionInst in   32    encoding of trapping instruction
//   io_coreid        in   8     hart id, passed through unregistered
//   out_ready        in   1     difftest sink may consume this cycle (step throttle)
//   out_valid        out  1     head entry valid; drives sink enable and io_valid
//   out_interrupt    out  32    head entry interrupt
//   out_exception    out  32    head entry exception
//   out_exceptionPC  out  64    head entry PC
//   out_exceptionInst out 32    head entry instruction
//   out_coreid       out  8     = io_coreid
//   overflow         out  1     sticky: at least one event dropped since reset
//   drop_count       out  CNT_W number of dropped events, saturates at all-ones
// BEHAVIOUR
//   Reset: rd/wr pointers 0, count 0, out_valid 0, all out_* data 0, overflow 0, drop_count 0.
//   Normalise: ev_int = in_interrupt; ev_exc = (in_interrupt != 0) ? 0 : in_exception.
//   Qualify: push_req = in_valid && (ev_int != 0 || ev_exc != 0); in_valid with both causes 0 is ignored
//     (not stored, not counted).
//   Pop: pop = out_valid && out_ready.
//   Push accepted when push_req && (!full || pop); same-cycle push+pop on a full queue is legal,
//     and count is unchanged.
//   Drop: push_req && full && !pop -> entry discarded, overflow <= 1, drop_count += 1 unless all-ones.
//   Latency: event accepted in cycle N is visible on out_* in cycle N+1 if queue was empty
//     (no same-cycle bypass).
//   Ordering: strict FIFO; entries leave in acceptance order.
//   out_valid = (count != 0). When out_valid = 0, out_interrupt/exception/PC/Inst are forced to 0.
//   Pointers are log2(DEPTH) bits and wrap naturally; count is log2(DEPTH)+1 bits, range 0..DEPTH.
//   full = (count == DEPTH); empty = (count == 0). Pop on empty is impossible because pop requires
//     out_valid.
//   out_ready is ignored while empty. The head stays stable while out_ready = 0.
//   Reset mid-operation: queued entries are discarded, with no flush of pending events to the sink.
//     overflow and drop_count also clear.
// STRUCTURE
//   Package difftest_arch_event_pkg: typedef struct packed arch_event_t
//     {interrupt[31:0], exception[31:0], pc[63:0], inst[31:0]} (160 bits);
//     constant ARCH_EVENT_W = 160.
//   Sub-module difftest_sync_fifo #(WIDTH, DEPTH): storage, pointers, count, full/empty,
//     with simultaneous push/pop when full.
//   The top module holds the normalisation, drop accounting, output gating and coreid pass-through.
// TESTING
//   1 Single event: in_valid=1, int=0, exc=2, PC=0x8000_0010, inst=0x0000_0073, out_ready=1
//     -> next cycle out_valid=1 with the same fields; following cycle out_valid=0 with data 0.
//   2 Precedence: int=0x8000_0007, exc=5, same cycle -> out_interrupt=0x8000_0007, out_exception=0.
//   3 Spurious: in_valid=1, int=0, exc=0 -> out_valid stays 0; drop_count stays 0.
//   4 Fill and overflow: out_ready=0, push 5 events with DEPTH=4 -> first 4 retained in order,
//     overflow=1, drop_count=1. Then out_ready=1 -> 4 consecutive out_valid cycles with PCs in
//     push order.
//   5 Full with simultaneous push+pop: queue full, out_ready=1, push event E -> no drop; count
//     stays 4; E emerges 4th.
//   6 Reset mid-stream: 3 entries queued, overflow=1, then reset=1 for 1 cycle -> next cycle
//     out_valid=0, overflow=0, drop_count=0. A fresh event then appears with 1-cycle latency.

Source files
------------

// File: rtl/difftest_arch_event_pkg.sv
// Shared types for the difftest architectural-event queue: the queued event record
// and the cause-precedence normalisation applied before an event is stored.
package difftest_arch_event_pkg;

   typedef struct packed {
      logic [31:0] interrupt;
      logic [31:0] exception;
      logic [63:0] pc;
      logic [31:0] inst;
   } arch_event_t;

   localparam int ARCH_EVENT_W = 160;

   // An interrupt always masks a simultaneous exception.
   function automatic arch_event_t normalise_event(
      input logic [31:0] interrupt,
      input logic [31:0] exception,
      input logic [63:0] pc,
      input logic [31:0] inst
   );
      arch_event_t ev;
      ev.interrupt = interrupt;
      ev.exception = (interrupt != 32'd0) ? 32'd0 : exception;
      ev.pc        = pc;
      ev.inst      = inst;
      return ev;
   endfunction

   function automatic logic is_trap(input arch_event_t ev);
      return (ev.interrupt != 32'd0) || (ev.exception != 32'd0);
   endfunction

endpackage

// File: rtl/difftest_arch_event_queue_if.sv
// Commit-stage trap input, sink-side event output and loss status of the event queue.
interface difftest_arch_event_queue_if #(
   parameter int CNT_W = 16
);
   logic             in_valid;
   logic [31:0]      in_interrupt;
   logic [31:0]      in_exception;
   logic [63:0]      in_exceptionPC;
   logic [31:0]      in_exceptionInst;
   logic [7:0]       io_coreid;
   logic             out_ready;

   logic             out_valid;
   logic [31:0]      out_interrupt;
   logic [31:0]      out_exception;
   logic [63:0]      out_exceptionPC;
   logic [31:0]      out_exceptionInst;
   logic [7:0]       out_coreid;
   logic             overflow;
   logic [CNT_W-1:0] drop_count;

   modport master (
      output in_valid, in_interrupt, in_exception, in_exceptionPC, in_exceptionInst,
      output io_coreid, out_ready,
      input  out_valid, out_interrupt, out_exception, out_exceptionPC, out_exceptionInst,
      input  out_coreid, overflow, drop_count
   );

   modport slave (
      input  in_valid, in_interrupt, in_exception, in_exceptionPC, in_exceptionInst,
      input  io_coreid, out_ready,
      output out_valid, out_interrupt, out_exception, out_exceptionPC, out_exceptionInst,
      output out_coreid, overflow, drop_count
   );
endinterface

// File: rtl/difftest_sync_fifo.sv
// Single-clock FIFO with occupancy count; a push into a full FIFO is accepted
// when a pop happens in the same cycle.
module difftest_sync_fifo #(
   parameter int WIDTH = 160,
   parameter int DEPTH = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
   localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W:0]   count;
   logic             push_ok;
   logic             pop_ok;

   assign full    = (count == CNT_FULL);
   assign empty   = (count == '0);
   assign pop_ok  = pop && !empty;
   assign push_ok = push && (!full || pop_ok);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clock) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
         if (push_ok && !pop_ok)      count <= count + CNT_ONE;
         else if (!push_ok && pop_ok) count <= count - CNT_ONE;
      end
   end

   // NOTE: storage is deliberately not reset; count gates its visibility, so stale words never escape.
   always_ff @(posedge clock) begin
      if (push_ok) mem[wr_ptr] <= din;
   end

   assign dout = mem[rd_ptr];

endmodule

// File: rtl/difftest_arch_event_queue.sv
// Queues normalised trap events from commit towards the difftest sink, which has no
// backpressure; events that find the queue full are dropped and counted.
module difftest_arch_event_queue
   import difftest_arch_event_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
) (
   input logic                        clock,
   input logic                        reset,
   difftest_arch_event_queue_if.slave bus
);
   localparam logic [CNT_W-1:0] DROP_ONE = CNT_W'(1);

   arch_event_t      ev_in;
   arch_event_t      ev_head;
   logic             push_req;
   logic             pop;
   logic             fifo_full;
   logic             fifo_empty;
   logic             drop;
   logic             overflow_q;
   logic [CNT_W-1:0] drop_cnt;

   assign ev_in    = normalise_event(bus.in_interrupt, bus.in_exception,
                                     bus.in_exceptionPC, bus.in_exceptionInst);
   assign push_req = bus.in_valid && is_trap(ev_in);
   assign pop      = !fifo_empty && bus.out_ready;
   assign drop     = push_req && fifo_full && !pop;

   difftest_sync_fifo #(
      .WIDTH (ARCH_EVENT_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (push_req),
      .pop   (pop),
      .din   (ev_in),
      .dout  (ev_head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         overflow_q <= 1'b0;
         drop_cnt   <= '0;
      end else if (drop) begin
         overflow_q <= 1'b1;
         if (drop_cnt != '1) drop_cnt <= drop_cnt + DROP_ONE;
      end
   end

   // NOTE: every output gets a default first so this block can never infer a latch.
   always_comb begin
      bus.out_valid         = 1'b0;
      bus.out_interrupt     = '0;
      bus.out_exception     = '0;
      bus.out_exceptionPC   = '0;
      bus.out_exceptionInst = '0;
      if (!fifo_empty) begin
         bus.out_valid         = 1'b1;
         bus.out_interrupt     = ev_head.interrupt;
         bus.out_exception     = ev_head.exception;
         bus.out_exceptionPC   = ev_head.pc;
         bus.out_exceptionInst = ev_head.inst;
      end
   end

   assign bus.out_coreid = bus.io_coreid;
   assign bus.overflow   = overflow_q;
   assign bus.drop_count = drop_cnt;

endmodule

// File: tb/tb_difftest_arch_event_queue.sv
// Directed bench for the difftest architectural-event queue.
module tb_difftest_arch_event_queue;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   tests_run = 0;
   int   tests_failed = 0;

   always #5 clock = ~clock;

   difftest_arch_event_queue_if #(.CNT_W(16)) bus ();

   difftest_arch_event_queue #(
      .DEPTH (4),
      .CNT_W (16)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      tests_run++;
      assert (observed === expected)
      else begin
         tests_failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic [31:0] intr, input logic [31:0] exc,
                        input logic [63:0] pc, input logic [31:0] inst);
      bus.in_valid         = 1'b1;
      bus.in_interrupt     = intr;
      bus.in_exception     = exc;
      bus.in_exceptionPC   = pc;
      bus.in_exceptionInst = inst;
   endtask

   task automatic idle();
      bus.in_valid         = 1'b0;
      bus.in_interrupt     = '0;
      bus.in_exception     = '0;
      bus.in_exceptionPC   = '0;
      bus.in_exceptionInst = '0;
   endtask

   initial begin
      idle();
      bus.io_coreid = 8'h03;
      bus.out_ready = 1'b0;
      step();
      step();
      reset = 1'b0;

      // Reset state
      check("rst_valid",    64'(bus.out_valid), 64'd0);
      check("rst_pc",       bus.out_exceptionPC, 64'd0);
      check("rst_overflow", 64'(bus.overflow), 64'd0);
      check("rst_drops",    64'(bus.drop_count), 64'd0);
      check("coreid_3",     64'(bus.out_coreid), 64'h03);
      bus.io_coreid = 8'hA5;
      #1;
      check("coreid_a5",    64'(bus.out_coreid), 64'hA5);

      // 1: single event, one-cycle latency, then drained
      bus.out_ready = 1'b1;
      drive(32'd0, 32'd2, 64'h8000_0010, 32'h0000_0073);
      step();
      idle();
      check("t1_valid", 64'(bus.out_valid), 64'd1);
      check("t1_int",   64'(bus.out_interrupt), 64'd0);
      check("t1_exc",   64'(bus.out_exception), 64'd2);
      check("t1_pc",    bus.out_exceptionPC, 64'h8000_0010);
      check("t1_inst",  64'(bus.out_exceptionInst), 64'h73);
      step();
      check("t1_empty", 64'(bus.out_valid), 64'd0);
      check("t1_pc0",   bus.out_exceptionPC, 64'd0);
      check("t1_inst0", 64'(bus.out_exceptionInst), 64'd0);

      // 2: interrupt beats exception
      drive(32'h8000_0007, 32'd5, 64'h8000_0100, 32'h1234_5678);
      step();
      idle();
      check("t2_valid", 64'(bus.out_valid), 64'd1);
      check("t2_int",   64'(bus.out_interrupt), 64'h8000_0007);
      check("t2_exc",   64'(bus.out_exception), 64'd0);
      check("t2_pc",    bus.out_exceptionPC, 64'h8000_0100);
      step();

      // 3: spurious report is ignored
      drive(32'd0, 32'd0, 64'h8000_0200, 32'h0);
      step();
      idle();
      check("t3_valid", 64'(bus.out_valid), 64'd0);
      check("t3_drops", 64'(bus.drop_count), 64'd0);
      step();
      check("t3_valid2", 64'(bus.out_valid), 64'd0);

      // 4: fill with sink throttled, fifth event dropped
      bus.out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         drive(32'd0, 32'(i + 1), 64'h1000 + 64'(4 * i), 32'(i));
         step();
      end
      idle();
      check("t4_overflow", 64'(bus.overflow), 64'd1);
      check("t4_drops",    64'(bus.drop_count), 64'd1);
      check("t4_head",     bus.out_exceptionPC, 64'h1000);
      step();
      check("t4_stable",   bus.out_exceptionPC, 64'h1000);
      bus.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check($sformatf("t4_valid%0d", i), 64'(bus.out_valid), 64'd1);
         check($sformatf("t4_pc%0d", i), bus.out_exceptionPC, 64'h1000 + 64'(4 * i));
         check($sformatf("t4_exc%0d", i), 64'(bus.out_exception), 64'(i + 1));
         step();
      end
      check("t4_empty", 64'(bus.out_valid), 64'd0);

      // 5: push and pop together on a full queue
      bus.out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive(32'd0, 32'd3, 64'h2000 + 64'(4 * i), 32'h0);
         step();
      end
      bus.out_ready = 1'b1;
      drive(32'd0, 32'd3, 64'h2ABC, 32'h0);
      step();
      check("t5_no_drop", 64'(bus.drop_count), 64'd1);
      check("t5_head",    bus.out_exceptionPC, 64'h2004);
      // Queue must still be full: a push with no pop now drops
      bus.out_ready = 1'b0;
      drive(32'd0, 32'd3, 64'h2F00, 32'h0);
      step();
      idle();
      check("t5_full_drop", 64'(bus.drop_count), 64'd2);
      bus.out_ready = 1'b1;
      check("t5_pc0", bus.out_exceptionPC, 64'h2004);
      step();
      check("t5_pc1", bus.out_exceptionPC, 64'h2008);
      step();
      check("t5_pc2", bus.out_exceptionPC, 64'h200C);
      step();
      check("t5_pcE", bus.out_exceptionPC, 64'h2ABC);
      step();
      check("t5_empty", 64'(bus.out_valid), 64'd0);

      // 6: reset mid-stream discards the queue and loss status
      bus.out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive(32'd0, 32'd4, 64'h3000 + 64'(4 * i), 32'h0);
         step();
      end
      idle();
      check("t6_valid_pre", 64'(bus.out_valid), 64'd1);
      check("t6_ovf_pre",   64'(bus.overflow), 64'd1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("t6_valid", 64'(bus.out_valid), 64'd0);
      check("t6_ovf",   64'(bus.overflow), 64'd0);
      check("t6_drops", 64'(bus.drop_count), 64'd0);
      check("t6_pc",    bus.out_exceptionPC, 64'd0);
      bus.out_ready = 1'b1;
      drive(32'd9, 32'd0, 64'h4000, 32'hDEAD_BEEF);
      step();
      idle();
      check("t6_fresh_valid", 64'(bus.out_valid), 64'd1);
      check("t6_fresh_int",   64'(bus.out_interrupt), 64'd9);
      check("t6_fresh_pc",    bus.out_exceptionPC, 64'h4000);
      check("t6_fresh_inst",  64'(bus.out_exceptionInst), 64'hDEAD_BEEF);
      step();
      check("t6_drained", 64'(bus.out_valid), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
